// File: rtl/mem_arbiter_2p.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_2p
// Brief    : Two-requester arbiter serialising single-beat reads/writes onto
//            one single-port synchronous memory. Round-robin by default;
//            define ARB_FIXED_PRIO_EN for fixed priority (m0 wins ties).
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter_2p #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t          state_q,     state_d;
  logic            owner_q,     owner_d;
  logic            mem_we_q,    mem_we_d;
  logic [AW-1:0]   mem_addr_q,  mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            m0_gnt_q,    m0_gnt_d;
  logic            m1_gnt_q,    m1_gnt_d;
  logic            m0_rvalid_q, m0_rvalid_d;
  logic            m1_rvalid_q, m1_rvalid_d;
  logic [DW-1:0]   m0_rdata_q,  m0_rdata_d;
  logic [DW-1:0]   m1_rdata_q,  m1_rdata_d;
  logic            winner;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    winner = ~m0_req;
  end
`else
  // ptr_q names the requester favoured on a tie; reset favours m0.
  logic ptr_q, ptr_d;

  always_comb begin
    winner = 1'b0;
    if (m0_req && m1_req) begin
      winner = ptr_q;
    end else if (m1_req) begin
      winner = 1'b1;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    m0_gnt_d    = 1'b0;
    m1_gnt_d    = 1'b0;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
`ifndef ARB_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        // The memory port registers double as the request latch.
        if (m0_req || m1_req) begin
          state_d     = ISSUE;
          owner_d     = winner;
          mem_we_d    = winner ? m1_we    : m0_we;
          mem_addr_d  = winner ? m1_addr  : m0_addr;
          mem_wdata_d = winner ? m1_wdata : m0_wdata;
          m0_gnt_d    = ~winner;
          m1_gnt_d    = winner;
`ifndef ARB_FIXED_PRIO_EN
          ptr_d       = ~winner;
`endif
        end
      end
      ISSUE: begin
        state_d = mem_we_q ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        state_d = IDLE;
        if (owner_q) begin
          m1_rvalid_d = 1'b1;
          m1_rdata_d  = mem_rdata;
        end else begin
          m0_rvalid_d = 1'b1;
          m0_rdata_d  = mem_rdata;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      m0_gnt_q    <= m0_gnt_d;
      m1_gnt_q    <= m1_gnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

`ifndef ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign m0_gnt    = m0_gnt_q;
  assign m1_gnt    = m1_gnt_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_2p.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter_2p
// Brief    : Directed testbench for mem_arbiter_2p with a behavioural
//            256x32 synchronous memory model; checks sampled on negedge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter_2p;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [7:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  mem_arbiter_2p #(.AW(8), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Memory model; preload words 1 and 2 while reset is asserted.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[1]    <= 32'hA1A1_A1A1;
      mem[2]    <= 32'hB2B2_B2B2;
      mem_rdata <= 32'h0;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".mem_we"},    {31'd0, mem_we},    32'd0);
    check({tag, ".m0_gnt"},    {31'd0, m0_gnt},    32'd0);
    check({tag, ".m1_gnt"},    {31'd0, m1_gnt},    32'd0);
    check({tag, ".m0_rvalid"}, {31'd0, m0_rvalid}, 32'd0);
    check({tag, ".m1_rvalid"}, {31'd0, m1_rvalid}, 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check_quiet(tag);
    check({tag, ".mem_addr"},  {24'd0, mem_addr}, 32'd0);
    check({tag, ".mem_wdata"}, mem_wdata,         32'd0);
    check({tag, ".m0_rdata"},  m0_rdata,          32'd0);
    check({tag, ".m1_rdata"},  m1_rdata,          32'd0);
  endtask

  initial begin
    rst = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;

    // Reset held with random request activity
    for (int i = 0; i < 2; i++) begin
      m0_req = 1'($urandom); m0_we = 1'($urandom); m0_addr = 8'($urandom);
      m1_req = 1'($urandom); m1_we = 1'($urandom); m1_addr = 8'($urandom);
      m0_wdata = $urandom; m1_wdata = $urandom;
      @(negedge clk);
      check_reset("rst_hold");
    end
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    rst = 1'b1;
    @(negedge clk);
    check_quiet("post_rst_idle");

    // m0 write 0x10 <= DEADBEEF
    m0_req = 1; m0_we = 1; m0_addr = 8'h10; m0_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("wr.mem_we",    {31'd0, mem_we},    32'd1);
    check("wr.mem_addr",  {24'd0, mem_addr},  32'h10);
    check("wr.mem_wdata", mem_wdata,          32'hDEAD_BEEF);
    check("wr.m0_gnt",    {31'd0, m0_gnt},    32'd1);
    check("wr.m1_gnt",    {31'd0, m1_gnt},    32'd0);
    check("wr.m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
    check("wr.m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    m0_req = 0; m0_we = 0;
    @(negedge clk);
    check_quiet("wr.after");
    check("wr.addr_hold", {24'd0, mem_addr}, 32'h10);

    // m1 read 0x10
    m1_req = 1; m1_we = 0; m1_addr = 8'h10;
    @(negedge clk);
    check("rd1.m1_gnt",   {31'd0, m1_gnt},   32'd1);
    check("rd1.m0_gnt",   {31'd0, m0_gnt},   32'd0);
    check("rd1.mem_we",   {31'd0, mem_we},   32'd0);
    check("rd1.mem_addr", {24'd0, mem_addr}, 32'h10);
    m1_req = 0;
    @(negedge clk);
    check_quiet("rd1.rdwait");
    check("rd1.hold_addr", {24'd0, mem_addr}, 32'h10);
    @(negedge clk);
    check("rd1.m1_rvalid", {31'd0, m1_rvalid}, 32'd1);
    check("rd1.m1_rdata",  m1_rdata,           32'hDEAD_BEEF);
    check("rd1.m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
    check("rd1.m0_rdata",  m0_rdata,           32'd0);
    @(negedge clk);
    check_quiet("rd1.after");
    check("rd1.rdata_hold", m1_rdata, 32'hDEAD_BEEF);

`ifdef ARB_FIXED_PRIO_EN
    // Both requesting writes: m0 always wins; m1 only once m0 drops
    m0_req = 1; m0_we = 1; m0_addr = 8'h03; m0_wdata = 32'h0000_0003;
    m1_req = 1; m1_we = 1; m1_addr = 8'h04; m1_wdata = 32'h0000_0004;
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      check("fp.m0_gnt", {31'd0, m0_gnt}, {31'd0, (n <= 11) && (n % 2 == 1)});
      check("fp.m1_gnt", {31'd0, m1_gnt}, {31'd0, n == 13});
      if (n == 11) m0_req = 0;
      if (n == 13) begin
        check("fp.m1_addr", {24'd0, mem_addr}, 32'h04);
        m1_req = 0;
      end
    end
    m0_we = 0; m1_we = 0;
    @(negedge clk);
`else
    // Both requesting reads: grants alternate m0, m1, m0, m1
    m0_req = 1; m0_we = 0; m0_addr = 8'h01;
    m1_req = 1; m1_we = 0; m1_addr = 8'h02;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      check("rr.m0_gnt",    {31'd0, m0_gnt},    {31'd0, n == 1 || n == 7});
      check("rr.m1_gnt",    {31'd0, m1_gnt},    {31'd0, n == 4 || n == 10});
      check("rr.m0_rvalid", {31'd0, m0_rvalid}, {31'd0, n == 3 || n == 9});
      check("rr.m1_rvalid", {31'd0, m1_rvalid}, {31'd0, n == 6 || n == 12});
      check("rr.m0_rdata",  m0_rdata, (n >= 3) ? 32'hA1A1_A1A1 : 32'd0);
      check("rr.m1_rdata",  m1_rdata, (n >= 6) ? 32'hB2B2_B2B2 : 32'hDEAD_BEEF);
      if (n == 10) begin
        m0_req = 0; m1_req = 0;
      end
    end
    @(negedge clk);
    check_quiet("rr.after");
`endif

    // Reset during RDWAIT of an m0 read
    m0_req = 1; m0_we = 0; m0_addr = 8'h01;
    @(negedge clk);
    check("mid.m0_gnt", {31'd0, m0_gnt}, 32'd1);
    m0_req = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset("mid.rst_async");
    @(negedge clk);
    check_reset("mid.rst_cycle");
    rst = 1'b1;
    @(negedge clk);
    check_quiet("mid.post_rst");

    // m1 write 0x20 after reset, then m0 reads it back
    m1_req = 1; m1_we = 1; m1_addr = 8'h20; m1_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("w20.m1_gnt",    {31'd0, m1_gnt},   32'd1);
    check("w20.m0_gnt",    {31'd0, m0_gnt},   32'd0);
    check("w20.mem_we",    {31'd0, mem_we},   32'd1);
    check("w20.mem_addr",  {24'd0, mem_addr}, 32'h20);
    check("w20.mem_wdata", mem_wdata,         32'hCAFE_F00D);
    m1_req = 0; m1_we = 0;
    @(negedge clk);
    check_quiet("w20.after");
    m0_req = 1; m0_we = 0; m0_addr = 8'h20;
    @(negedge clk);
    check("r20.m0_gnt", {31'd0, m0_gnt}, 32'd1);
    m0_req = 0;
    @(negedge clk);
    @(negedge clk);
    check("r20.m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
    check("r20.m0_rdata",  m0_rdata,           32'hCAFE_F00D);
    check("r20.m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    check("r20.m1_rdata",  m1_rdata,           32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
